// File: rtl/rr_mux_arbiter_8.sv
// Round-robin arbiter driving select/en of an 8-input mux.
// Ports: clk, rst (async, active-high); req[7:0] per-source request;
//   last (end of burst, qualified by xfer); ready (consumer accepts);
//   select[2:0], en (registered); grant[7:0] one-hot of select while en;
//   xfer = en & ready & req[select].
module rr_mux_arbiter_8 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       last,
  input  logic       ready,
  output logic [2:0] select,
  output logic       en,
  output logic [7:0] grant,
  output logic       xfer
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [CNT_W-1:0] LAST_BEAT =
    CNT_W'(MAX_HOLD - 1);

  state_t           state, state_n;
  logic [2:0]       ptr, ptr_n;
  logic [2:0]       sel_n;
  logic             en_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [7:0]       rot;
  logic [2:0]       off;
  logic [2:0]       win;
  logic             done;

  assign xfer  = en & ready & req[select];
  assign grant = en ? (8'd1 << select) : 8'd0;

  // Rotate so bit 0 is the current top-priority
  // source, then take the lowest set bit.
  always_comb begin
    rot = 8'({req, req} >> ptr);
    off = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rot[i]) off = 3'(i);
    end
    win = ptr + off;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      select <= 3'd0;
      en     <= 1'b0;
      ptr    <= 3'd0;
      cnt    <= '0;
    end else begin
      state  <= state_n;
      select <= sel_n;
      en     <= en_n;
      ptr    <= ptr_n;
      cnt    <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    sel_n   = select;
    en_n    = en;
    ptr_n   = ptr;
    cnt_n   = cnt;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (|req) begin
          sel_n   = win;
          en_n    = 1'b1;
          cnt_n   = '0;
          state_n = BUSY;
        end
      end
      BUSY: begin
        // A withdrawn source ends the grant
        // with no transfer in that cycle.
        if (!req[select]) begin
          done = 1'b1;
        end else if (xfer) begin
          cnt_n = cnt + CNT_W'(1);
          if (last || cnt == LAST_BEAT)
            done = 1'b1;
        end
        if (done) begin
          en_n    = 1'b0;
          ptr_n   = select + 3'd1;
          state_n = IDLE;
        end
      end
    endcase
  end

endmodule

// File: doc/rr_mux_arbiter_8.md
Name: rr_mux_arbiter_8

Overview:
- Round-robin arbiter that sits directly upstream of the 8-input width-parameterised mux.
- It picks one of eight requesting sources and drives the mux `select` and `en` inputs.
- It holds the grant for a burst of transfers to a single downstream consumer.
- It bounds the burst length so that no source can starve the others.

Parameters:
- MAX_HOLD, 16: maximum transfers per grant; legal range 1..256.
- CNT_W, 8: width of the internal beat counter; must satisfy 2^CNT_W >= MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  per-source request; bit k is source k (mux input i_k).
- last  input  1  end-of-burst flag from the currently selected source; qualified by a transfer.
- ready  input  1  downstream consumer accepts the mux output this cycle.
- select  output  3  mux select, registered.
- en  output  1  mux enable, registered; high only while a grant is active.
- grant  output  8  one-hot copy of select while en=1; all zero otherwise.
- xfer  output  1  combinational; equals en & ready & req[select]. Marks a completed transfer.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - select=0, en=0, grant=0, priority pointer ptr=0, beat counter=0.
  - Asserting rst mid-burst aborts the grant immediately; no transfer completes in that cycle.
- States: IDLE and BUSY.
- IDLE:
  - If req != 0, the winner is the first set bit scanning ptr, ptr+1, ..., ptr+7, with indices taken mod 8.
  - On the next edge: select <= winner, en <= 1, counter <= 0, go to BUSY.
  - Latency is exactly 1 cycle from a sampled request to en=1.
  - If req == 0, stay in IDLE with en=0. select keeps its last value, which is don't-care for the mux because en=0.
- BUSY:
  - The counter increments on each xfer.
  - The grant ends on the edge where any of the following holds:
    - (a) xfer & last;
    - (b) xfer & counter == MAX_HOLD-1;
    - (c) req[select] == 0, i.e. the source withdrew; no transfer occurs in that cycle.
  - On grant end: en <= 0, ptr <= select+1 (mod 8, so 7 wraps to 0), return to IDLE.
  - If ready=0 the grant holds indefinitely. The stall is not counted, and a stall never ends a grant.
- Turnaround: exactly one IDLE cycle (en=0) between consecutive grants, even with requests pending. This guarantees the mux output floats for one cycle at every handover.
- Simultaneous events:
  - (a) and (b) in the same cycle end the grant once, with the same result.
  - Other sources' req changes while BUSY have no effect until IDLE.
- Fairness: after k is served, k has the lowest priority. A source that requests continuously is granted within 8 grants.
- grant is derived from the registered select and en, so it is glitch-free.
- The counter saturates logic-wise because it is reset on every new grant. MAX_HOLD=1 yields single-beat grants.

Test Plan:
- Reset, then req=8'b0000_0100 with ready=1 and last asserted on the 3rd xfer -> en rises 1 cycle after req. select=2, grant=8'h04, 3 xfer pulses, en falls, ptr=3.
- req=8'hFF held, ready=1, last=1 every beat -> grants go to sources 0,1,...,7,0 in order. en pattern is 1,0,1,0... and select wraps from 7 to 0.
- MAX_HOLD=4, req=8'h01 held, last=0, ready=1 -> exactly 4 xfers, then 1 idle cycle, then source 0 is re-granted. No other requester is present.
- req=8'h81 (sources 0 and 7) with ptr=5 -> source 7 wins. After release, source 0 wins next.
- Grant to source 3 with ready=0 for 10 cycles, then req[3] drops -> no xfer, counter stays 0, en falls on the next edge, ptr=4.
- Assert rst mid-burst for source 6 -> en=0, select=0, grant=0 asynchronously. After release, arbitration restarts from ptr=0.
